sample_rr_arbiter: RTL and testbench
====================================

# sample_rr_arbiter

Four-way round-robin arbiter that shares one WIDTH-bit sample path between four independent point-generator lanes of the Pi estimator. Each lane offers a sample with a valid/ready handshake. The arbiter selects one lane per transfer, forms the 2-bit select for the shared bus multiplexer, and registers the chosen sample into a single output stage consumed by the hit accumulator. It also keeps a running count of delivered samples.

## Interface
- WIDTH, 64, sample width in bits
- CNT_W, 32, width of the delivered-sample counter
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  4  lane i is offering a sample
- req_data  input  4*WIDTH  lane i sample on bits [i*WIDTH +: WIDTH]
- req_ready  output  4  one-hot; lane i sample is taken at this clock edge
- out_valid  output  1  output register holds a sample
- out_data  output  WIDTH  registered sample
- out_ready  input  1  consumer takes out_data this edge when out_valid is also high
- grant_sel  output  2  index of the lane that sourced the current out_data
- xfer_count  output  CNT_W  number of samples delivered on the output

## Operation
- Output stage is a one-entry register with two states:
  - EMPTY: out_valid=0
  - FULL: out_valid=1
- Load enable: load = (EMPTY or (FULL and out_ready)) and |req_valid.
- Priority rotates. The search starts at lane (last+1) mod 4 and wraps 3→0. The first lane with req_valid=1 wins.
- `last` is updated to the winner only on a load. Lanes that are not accepted keep their position.
- req_ready = load ? onehot(winner) : 4'b0000. This is combinational from req_valid, out_ready and the state. Lanes must not make req_valid depend on req_ready.
- The bus select feeding the shared mux is the combinational winner index. On a load, out_data, grant_sel and `last` are registered from it.
- State transitions:
  - EMPTY→FULL on load.
  - FULL→FULL on load.
  - FULL→EMPTY when out_ready=1 and no lane is valid.
  - FULL stays FULL with out_data held stable while out_ready=0.
- xfer_count increments by 1 on every edge where out_valid and out_ready are both 1. It wraps from 2^CNT_W−1 to 0 with no saturation.
- A lane that holds req_valid high without being granted keeps its data stable. The arbiter never drops or duplicates a sample.

## Timing
- Reset values:
  - state EMPTY, out_valid=0, out_data=0, grant_sel=0
  - last=3, so lane 0 has first priority
  - xfer_count=0
  - req_ready=0, since load is impossible with no valid lanes
- Latency: a sample accepted at edge N appears on out_data/out_valid immediately after edge N, i.e. one cycle.
- Throughput: one sample per clock while out_ready=1 and at least one lane is valid.
- Fairness: with all four lanes continuously valid, the grant order is 0,1,2,3,0,… Each lane waits at most 3 transfers.
- Consume and load on the same edge: the old sample is delivered and counted, the new sample is loaded, and out_valid stays 1.
- rst asserted mid-transfer: on that edge all registers take their reset values, the pending output sample is discarded, and req_ready is 0 during the reset cycle.

## Structure
- Shared constants file holds NUM_LANES=4 and SEL_W=2, used by this block and the bus mux instantiation.
- Sub-module rr_pick_4 is combinational. Its inputs are req_valid[3:0] and last[1:0]. Its outputs are winner[1:0] and any.
- The top level holds the FSM, the output register, `last`, and xfer_count. The lane sample bus is selected through the existing 4:1 bus multiplexer, driven by winner.

## Test plan
- Reset release with no requests: out_valid=0, req_ready=0000, grant_sel=0, xfer_count=0 for 10 cycles.
- Only lane 2 valid, data 0xA5A5…, out_ready=1:
  - req_ready=0100 on the first edge
  - next cycle out_valid=1, out_data=0xA5A5…, grant_sel=2
  - xfer_count=1 one edge later
- All lanes valid, out_ready=1 for 8 cycles: grant_sel sequence 0,1,2,3,0,1,2,3 and xfer_count=8.
- Backpressure: lanes 0 and 1 valid, out_ready=0 for 5 cycles.
  - out_data holds the lane-0 sample and req_ready=0000 throughout
  - raising out_ready loads lane 1 on that edge
- Counter wrap: CNT_W=4, 17 transfers → xfer_count reads 1.
- rst pulsed while FULL with out_ready=0: next cycle out_valid=0 and xfer_count=0. The first grant after reset goes to lane 0.

Source files
------------

// File: rtl/sample_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sample_rr_arbiter_pkg
// Brief    : Shared lane-count constants and output-stage state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package sample_rr_arbiter_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick_4
// Brief    : Combinational 4-way round-robin pick starting after lane i_last.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick_4
    import sample_rr_arbiter_pkg::*;
(
    input  logic [NUM_LANES-1:0] i_req_valid,
    input  logic [SEL_W-1:0]     i_last,
    output logic [SEL_W-1:0]     o_winner,
    output logic                 o_any
);

    logic [SEL_W-1:0]       w_start;
    logic [SEL_W-1:0]       w_off;
    logic [2*NUM_LANES-1:0] w_dbl;
    logic [NUM_LANES-1:0]   w_rot;

    assign w_start = i_last + SEL_W'(1);
    assign w_dbl   = {i_req_valid, i_req_valid};
    // w_rot[k] is the lane k positions past the start, so bit 0 has top priority
    assign w_rot   = w_dbl[w_start +: NUM_LANES];

    always_comb begin
        w_off = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SEL_W'(k);
            end
        end
    end

    assign o_winner = w_start + w_off;
    assign o_any    = |i_req_valid;

endmodule
`default_nettype wire

// File: rtl/sample_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sample_rr_arbiter
// Brief    : Round-robin share of one sample path between four lanes, with a
//            one-entry registered output stage and delivered-sample counter.
// Revision : 1.0 - initial release
// ============================================================================
module sample_rr_arbiter
    import sample_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LANES-1:0]       i_req_valid,
    input  logic [NUM_LANES*WIDTH-1:0] i_req_data,
    output logic [NUM_LANES-1:0]       o_req_ready,
    output logic                       o_out_valid,
    output logic [WIDTH-1:0]           o_out_data,
    input  logic                       i_out_ready,
    output logic [SEL_W-1:0]           o_grant_sel,
    output logic [CNT_W-1:0]           o_xfer_count
);

    out_state_t        r_state;
    logic [SEL_W-1:0]  r_last;
    logic [SEL_W-1:0]  r_grant_sel;
    logic [WIDTH-1:0]  r_out_data;
    logic [CNT_W-1:0]  r_xfer_count;

    logic [SEL_W-1:0]  w_winner;
    logic              w_any;
    logic              w_load;
    logic [WIDTH-1:0]  w_lane [NUM_LANES];
    logic [WIDTH-1:0]  w_sel_data;

    rr_pick_4 u_pick (
        .i_req_valid (i_req_valid),
        .i_last      (r_last),
        .o_winner    (w_winner),
        .o_any       (w_any)
    );

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign w_lane[gi] = i_req_data[gi*WIDTH +: WIDTH];
    end

    assign w_sel_data = w_lane[w_winner];

    // Reset is folded in so no lane sees a handshake during the reset cycle
    assign w_load = !rst && w_any && (r_state == ST_EMPTY || i_out_ready);

    assign o_req_ready  = w_load ? (NUM_LANES'(1) << w_winner) : '0;
    assign o_out_valid  = (r_state == ST_FULL);
    assign o_out_data   = r_out_data;
    assign o_grant_sel  = r_grant_sel;
    assign o_xfer_count = r_xfer_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_EMPTY;
            r_out_data   <= '0;
            r_grant_sel  <= '0;
            r_last       <= SEL_W'(NUM_LANES - 1);
            r_xfer_count <= '0;
        end else begin
            if (r_state == ST_FULL && i_out_ready) begin
                r_xfer_count <= r_xfer_count + CNT_W'(1);
            end

            if (w_load) begin
                r_out_data  <= w_sel_data;
                r_grant_sel <= w_winner;
                r_last      <= w_winner;
            end

            case (r_state)
                ST_EMPTY: begin
                    if (w_load) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!w_load && i_out_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sample_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_rr_arbiter
// Brief    : Directed and random checks of sample_rr_arbiter against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_rr_arbiter;

    localparam int W  = 64;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     vld = 4'b0000;
    logic [W-1:0]   ld [4];
    logic [4*W-1:0] bus;
    logic           ordy = 1'b0;

    logic [3:0]     o_req_ready;
    logic           o_out_valid;
    logic [W-1:0]   o_out_data;
    logic [1:0]     o_grant_sel;
    logic [CW-1:0]  o_xfer_count;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) bus[i*W +: W] = ld[i];
    end

    sample_rr_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (vld),
        .i_req_data   (bus),
        .o_req_ready  (o_req_ready),
        .o_out_valid  (o_out_valid),
        .o_out_data   (o_out_data),
        .i_out_ready  (ordy),
        .o_grant_sel  (o_grant_sel),
        .o_xfer_count (o_xfer_count)
    );

    // Behavioural model of the output stage
    bit         m_full;
    logic [W-1:0] m_data;
    int         m_sel, m_last, m_cnt;
    bit         rand_mode;
    int         total, bad;

    function automatic int pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_data = '0; m_sel = 0; m_last = 3; m_cnt = 0;
    endtask

    task automatic step();
        int         w;
        bit         load;
        logic [3:0] exp_rdy;
        #1;
        w       = pick(vld, m_last);
        load    = !rst && (w >= 0) && (!m_full || ordy);
        exp_rdy = load ? 4'(1 << w) : 4'b0000;
        chk("req_ready", {60'd0, o_req_ready}, {60'd0, exp_rdy});
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_full && ordy) m_cnt = (m_cnt + 1) % (1 << CW);
            if (load) begin
                m_full = 1; m_data = ld[w]; m_sel = w; m_last = w;
            end else if (m_full && ordy) begin
                m_full = 0;
            end
        end
        #1;
        chk("out_valid", {63'd0, o_out_valid}, {63'd0, m_full});
        chk("out_data", o_out_data, m_data);
        chk("grant_sel", {62'd0, o_grant_sel}, 64'(m_sel));
        chk("xfer_count", {60'd0, o_xfer_count}, 64'(m_cnt));
        // a granted lane moves on to a fresh sample; waiting lanes hold theirs
        if (load) begin
            ld[w] = {$urandom, $urandom};
            if (rand_mode) vld[w] = 1'($urandom_range(0, 1));
        end
        if (rand_mode) begin
            for (int i = 0; i < 4; i++) begin
                if (!vld[i]) begin
                    vld[i] = ($urandom_range(0, 3) != 0);
                    ld[i]  = {$urandom, $urandom};
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; rand_mode = 0;
        for (int i = 0; i < 4; i++) ld[i] = {$urandom, $urandom};
        model_reset();

        // Idle after reset
        do_reset();
        for (int i = 0; i < 10; i++) step();
        chk("idle_valid", {63'd0, o_out_valid}, 64'd0);
        chk("idle_cnt", {60'd0, o_xfer_count}, 64'd0);

        // Single lane 2
        ld[2] = 64'hA5A5_A5A5_A5A5_A5A5;
        vld = 4'b0100; ordy = 1'b1;
        #1 chk("lane2_ready", {60'd0, o_req_ready}, 64'h4);
        step();
        vld = 4'b0000;
        chk("lane2_data", o_out_data, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("lane2_sel", {62'd0, o_grant_sel}, 64'd2);
        step();
        chk("lane2_cnt", {60'd0, o_xfer_count}, 64'd1);

        // All lanes: strict 0,1,2,3 rotation
        do_reset();
        vld = 4'b1111; ordy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_order", {62'd0, o_grant_sel}, 64'(i % 4));
        end
        vld = 4'b0000;
        step();
        chk("rr_cnt", {60'd0, o_xfer_count}, 64'd8);

        // Backpressure on lanes 0 and 1
        do_reset();
        vld = 4'b0011; ordy = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        chk("bp_sel", {62'd0, o_grant_sel}, 64'd0);
        ordy = 1'b1;
        step();
        chk("bp_release_sel", {62'd0, o_grant_sel}, 64'd1);
        vld = 4'b0000;
        step();

        // Counter wrap with a 4-bit counter: 17 deliveries
        do_reset();
        vld = 4'b0001; ordy = 1'b1;
        for (int i = 0; i < 17; i++) step();
        vld = 4'b0000;
        step();
        chk("cnt_wrap", {60'd0, o_xfer_count}, 64'd1);

        // Reset while FULL and stalled
        vld = 4'b1010; ordy = 1'b0;
        step();
        step();
        do_reset();
        chk("rst_valid", {63'd0, o_out_valid}, 64'd0);
        chk("rst_cnt", {60'd0, o_xfer_count}, 64'd0);
        vld = 4'b1111;
        step();
        chk("rst_first_grant", {62'd0, o_grant_sel}, 64'd0);

        // Randomized traffic
        rand_mode = 1;
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
